// File: rtl/flag_branch_unit_if.sv
// Bundles the ALU flag inputs, branch request/pipeline controls and the
// registered flag/decision/counter outputs of flag_branch_unit.
interface flag_branch_unit_if #(
  parameter int CNT_W = 32
);
  logic             alu_zero;
  logic             alu_negative;
  logic             alu_carry;
  logic             alu_overflow;
  logic             set_flags;
  logic             br_valid;
  logic [1:0]       br_type;
  logic [3:0]       cond;
  logic             stall;
  logic             flush;
  logic [3:0]       flags;
  logic             br_out_valid;
  logic             br_taken;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output alu_zero, alu_negative, alu_carry, alu_overflow, set_flags,
    output br_valid, br_type, cond, stall, flush,
    input  flags, br_out_valid, br_taken, taken_count
  );

  modport slave (
    input  alu_zero, alu_negative, alu_carry, alu_overflow, set_flags,
    input  br_valid, br_type, cond, stall, flush,
    output flags, br_out_valid, br_taken, taken_count
  );
endinterface

// File: rtl/flag_branch_unit.sv
// NZCV flag register plus branch evaluation (B.cond/CBZ/CBNZ/B) with a
// one-cycle registered decision and a saturating taken-branch counter.
module flag_branch_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  flag_branch_unit_if.slave bus
);

  logic [3:0]       flags_q, flags_d;
  logic             valid_q, valid_d;
  logic             taken_q, taken_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [3:0] alu_nzcv;
  logic [3:0] eff;
  logic       eff_n, eff_z, eff_c, eff_v;
  logic       cond_true;
  logic       taken;
  logic       advance;

  assign alu_nzcv = {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow};
  // Bypass lets a B.cond right behind ADDS/SUBS see the new flags without a bubble.
  assign eff      = bus.set_flags ? alu_nzcv : flags_q;
  assign {eff_n, eff_z, eff_c, eff_v} = eff;
  assign advance  = !bus.stall && !bus.flush;

  always_comb begin
    cond_true = 1'b1;
    unique case (bus.cond)
      4'h0: cond_true = eff_z;
      4'h1: cond_true = !eff_z;
      4'h2: cond_true = eff_c;
      4'h3: cond_true = !eff_c;
      4'h4: cond_true = eff_n;
      4'h5: cond_true = !eff_n;
      4'h6: cond_true = eff_v;
      4'h7: cond_true = !eff_v;
      4'h8: cond_true = eff_c && !eff_z;
      4'h9: cond_true = !eff_c || eff_z;
      4'hA: cond_true = (eff_n == eff_v);
      4'hB: cond_true = (eff_n != eff_v);
      4'hC: cond_true = !eff_z && (eff_n == eff_v);
      4'hD: cond_true = eff_z || (eff_n != eff_v);
      default: cond_true = 1'b1;  // AL and NV both execute
    endcase
  end

  always_comb begin
    taken = 1'b1;
    unique case (bus.br_type)
      2'b00: taken = cond_true;
      2'b01: taken = bus.alu_zero;
      2'b10: taken = !bus.alu_zero;
      default: taken = 1'b1;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    valid_d = valid_q;
    taken_d = taken_q;
    count_d = count_q;
    if (advance && bus.set_flags) begin
      flags_d = alu_nzcv;
    end
    if (bus.flush) begin
      valid_d = 1'b0;
      taken_d = 1'b0;
    end else if (!bus.stall) begin
      valid_d = bus.br_valid;
      taken_d = bus.br_valid && taken;
      if (bus.br_valid && taken && (count_q != {CNT_W{1'b1}})) begin
        count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= 4'b0000;
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      count_q <= '0;
    end else begin
      flags_q <= flags_d;
      valid_q <= valid_d;
      taken_q <= taken_d;
      count_q <= count_d;
    end
  end

  assign bus.flags        = flags_q;
  assign bus.br_out_valid = valid_q;
  assign bus.br_taken     = taken_q;
  assign bus.taken_count  = count_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench for flag_branch_unit: directed vector table, full
// condition sweep, async reset checks, random stimulus and counter saturation.
module tb_flag_branch_unit;

  logic clk;
  logic reset;

  flag_branch_unit_if #(.CNT_W(32)) bus ();
  flag_branch_unit_if #(.CNT_W(4))  bus_s ();

  flag_branch_unit #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  flag_branch_unit #(.CNT_W(4))  dut_s (.clk(clk), .reset(reset), .bus(bus_s.slave));

  assign bus_s.alu_zero     = bus.alu_zero;
  assign bus_s.alu_negative = bus.alu_negative;
  assign bus_s.alu_carry    = bus.alu_carry;
  assign bus_s.alu_overflow = bus.alu_overflow;
  assign bus_s.set_flags    = bus.set_flags;
  assign bus_s.br_valid     = bus.br_valid;
  assign bus_s.br_type      = bus.br_type;
  assign bus_s.cond         = bus.cond;
  assign bus_s.stall        = bus.stall;
  assign bus_s.flush        = bus.flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       sf;
    bit [3:0] nzcv;
    bit       bv;
    bit [1:0] bt;
    bit [3:0] cond;
    bit       st;
    bit       fl;
  } in_t;

  typedef struct {
    in_t      i;
    bit [3:0] ef;
    bit       ev;
    bit       et;
    int       ec;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference state
  bit [3:0] m_flags;
  bit       m_valid;
  bit       m_taken;
  longint   m_count;
  longint   m_small;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ARM ConditionHolds: pairs of conditions share a base test, odd codes invert it (except NV).
  function automatic bit cond_holds(input bit [3:0] c, input bit [3:0] f);
    bit n, z, cy, v, r;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c[0] && c != 4'hF) r = !r;
    return r;
  endfunction

  function automatic in_t mk(input bit sf, input bit [3:0] nzcv, input bit bv,
                             input bit [1:0] bt, input bit [3:0] cond,
                             input bit st, input bit fl);
    in_t r;
    r.sf = sf; r.nzcv = nzcv; r.bv = bv; r.bt = bt; r.cond = cond; r.st = st; r.fl = fl;
    return r;
  endfunction

  function automatic vec_t mv(input in_t i, input bit [3:0] ef, input bit ev,
                              input bit et, input int ec);
    vec_t r;
    r.i = i; r.ef = ef; r.ev = ev; r.et = et; r.ec = ec;
    return r;
  endfunction

  task automatic model_reset();
    m_flags = 4'b0; m_valid = 1'b0; m_taken = 1'b0; m_count = 0; m_small = 0;
  endtask

  // Drive one cycle of inputs, advance the model, and wait until just past the edge.
  task automatic step(input in_t i);
    bit [3:0] eff;
    bit       tk;
    bus.set_flags    = i.sf;
    {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow} = i.nzcv;
    bus.br_valid     = i.bv;
    bus.br_type      = i.bt;
    bus.cond         = i.cond;
    bus.stall        = i.st;
    bus.flush        = i.fl;
    eff = i.sf ? i.nzcv : m_flags;
    case (i.bt)
      2'b00: tk = cond_holds(i.cond, eff);
      2'b01: tk = i.nzcv[2];
      2'b10: tk = !i.nzcv[2];
      default: tk = 1'b1;
    endcase
    if (!i.st && !i.fl && i.sf) m_flags = i.nzcv;
    if (i.fl) begin
      m_valid = 0; m_taken = 0;
    end else if (!i.st) begin
      m_valid = i.bv;
      m_taken = i.bv && tk;
      if (i.bv && tk) begin
        if (m_count < 64'hFFFF_FFFF) m_count++;
        if (m_small < 15) m_small++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".flags"}, bus.flags, m_flags);
    check({tag, ".valid"}, bus.br_out_valid, m_valid);
    check({tag, ".taken"}, bus.br_taken, m_taken);
    check({tag, ".count"}, bus.taken_count, m_count);
    check({tag, ".count4"}, bus_s.taken_count, m_small);
  endtask

  vec_t vecs[19];
  in_t  idle;

  initial begin
    idle = mk(0, 4'b0, 0, 2'b00, 4'h0, 0, 0);

    vecs[0]  = mv(mk(1, 4'b1010, 0, 2'b00, 4'h0, 0, 0), 4'b1010, 0, 0, 0);
    vecs[1]  = mv(mk(1, 4'b0101, 0, 2'b00, 4'h0, 1, 0), 4'b1010, 0, 0, 0);
    vecs[2]  = mv(mk(1, 4'b0101, 0, 2'b00, 4'h0, 0, 1), 4'b1010, 0, 0, 0);
    vecs[3]  = mv(mk(1, 4'b0000, 0, 2'b00, 4'h0, 0, 0), 4'b0000, 0, 0, 0);
    vecs[4]  = mv(mk(1, 4'b0100, 1, 2'b00, 4'h0, 0, 0), 4'b0100, 1, 1, 1);  // bypass EQ
    vecs[5]  = mv(mk(1, 4'b0000, 0, 2'b00, 4'h0, 0, 0), 4'b0000, 0, 0, 1);
    vecs[6]  = mv(mk(1, 4'b0100, 1, 2'b00, 4'h1, 0, 0), 4'b0100, 1, 0, 1);  // bypass NE
    vecs[7]  = mv(mk(0, 4'b0100, 1, 2'b01, 4'h0, 0, 0), 4'b0100, 1, 1, 2);  // CBZ
    vecs[8]  = mv(mk(0, 4'b0100, 1, 2'b10, 4'h0, 0, 0), 4'b0100, 1, 0, 2);  // CBNZ
    vecs[9]  = mv(mk(0, 4'b0000, 1, 2'b11, 4'h0, 0, 0), 4'b0100, 1, 1, 3);  // B
    vecs[10] = mv(mk(0, 4'b0000, 0, 2'b11, 4'h0, 0, 0), 4'b0100, 0, 0, 3);
    vecs[11] = mv(mk(0, 4'b0000, 1, 2'b11, 4'h0, 0, 0), 4'b0100, 1, 1, 4);
    vecs[12] = mv(mk(0, 4'b0000, 1, 2'b11, 4'h0, 1, 0), 4'b0100, 1, 1, 4);
    vecs[13] = mv(mk(0, 4'b0000, 0, 2'b11, 4'h0, 1, 0), 4'b0100, 1, 1, 4);
    vecs[14] = mv(mk(0, 4'b0000, 1, 2'b11, 4'h0, 1, 0), 4'b0100, 1, 1, 4);
    vecs[15] = mv(mk(0, 4'b0000, 1, 2'b11, 4'h0, 1, 1), 4'b0100, 0, 0, 4);  // flush beats stall
    vecs[16] = mv(mk(0, 4'b0000, 1, 2'b11, 4'h0, 0, 1), 4'b0100, 0, 0, 4);
    vecs[17] = mv(mk(1, 4'b1001, 1, 2'b00, 4'hA, 0, 0), 4'b1001, 1, 1, 5);  // GE
    vecs[18] = mv(mk(1, 4'b0100, 1, 2'b00, 4'hC, 0, 0), 4'b0100, 1, 0, 5);  // GT

    // Reset held with inputs toggling
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      step(mk(1, 4'($urandom), 1, 2'($urandom), 4'($urandom), 0, 0));
      model_reset();
      check("rst_hold.flags", bus.flags, 4'b0);
      check("rst_hold.valid", bus.br_out_valid, 1'b0);
      check("rst_hold.count", bus.taken_count, 0);
    end
    reset = 1'b1;
    step(idle);
    check_model("rst_rel");

    // Directed table
    for (int k = 0; k < 19; k++) begin
      step(vecs[k].i);
      check($sformatf("vec%0d.flags", k), bus.flags, vecs[k].ef);
      check($sformatf("vec%0d.valid", k), bus.br_out_valid, vecs[k].ev);
      check($sformatf("vec%0d.taken", k), bus.br_taken, vecs[k].et);
      check($sformatf("vec%0d.count", k), bus.taken_count, vecs[k].ec);
      $display("vec %0d flags=%b valid=%0b taken=%0b count=%0d", k,
               bus.flags, bus.br_out_valid, bus.br_taken, bus.taken_count);
    end

    // Condition sweep over all NZCV x cond via the bypass path
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        step(mk(1, 4'(f), 1, 2'b00, 4'(c), 0, 0));
        check($sformatf("sweep f=%b c=%h", 4'(f), 4'(c)), bus.br_taken, cond_holds(4'(c), 4'(f)));
      end
    end
    $display("sweep done count=%0d", bus.taken_count);

    // Asynchronous reset mid-stream with a valid decision pending
    step(mk(0, 4'b0, 1, 2'b11, 4'h0, 0, 0));
    check("pre_async.valid", bus.br_out_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("async.flags", bus.flags, 4'b0);
    check("async.valid", bus.br_out_valid, 1'b0);
    check("async.taken", bus.br_taken, 1'b0);
    check("async.count", bus.taken_count, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();

    // Random stimulus against the reference model
    for (int k = 0; k < 2000; k++) begin
      in_t r;
      r = mk(1'($urandom), 4'($urandom), 1'($urandom), 2'($urandom), 4'($urandom),
             ($urandom_range(7) == 0), ($urandom_range(15) == 0));
      step(r);
      check_model($sformatf("rnd%0d", k));
    end
    $display("random done count=%0d count4=%0d", bus.taken_count, bus_s.taken_count);

    // Saturation of the 4-bit counter
    reset = 1'b0;
    #1;
    reset = 1'b1;
    model_reset();
    for (int k = 0; k < 20; k++) begin
      step(mk(0, 4'b0, 1, 2'b11, 4'h0, 0, 0));
    end
    check("sat.count4", bus_s.taken_count, 15);
    check("sat.count32", bus.taken_count, 20);
    check_model("sat");
    $display("saturation count4=%0d count32=%0d", bus_s.taken_count, bus.taken_count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
